// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: multi-cycle radix-2 shift-add multiply sequencer for the CPU MUL path.
// The CPU stays stalled while a multiply is in flight. The registered 2*WIDTH-bit product
// is presented with a one-cycle done pulse, which acts as the MUL write-back enable.
//
// Ports:
//   clk        CPU clock; every state change happens on the rising edge
//   reset      synchronous, active-high
//   start      multiply request (sampled in IDLE only)
//   signed_op  1 = two's-complement operands, 0 = unsigned (sampled with start)
//   cancel     synchronous abort; beats a simultaneous start
//   src1/src2  multiplicand / multiplier (sampled with start)
//   busy       registered, high during RUN and FIX
//   stall      combinational: busy | (start & idle & ~cancel)
//   done       registered one-cycle completion pulse
//   result_lo  registered low half of the product, held until the next completion
//   result_hi  registered high half of the product, held until the next completion
module mul_seq_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic             cancel,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]      ONE_C  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]      LAST_C = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_lo_q, result_lo_d;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;

  logic [WIDTH-1:0]   mag1, mag2;

  // Operand magnitudes; |-2^(WIDTH-1)| wraps back to 2^(WIDTH-1), which is
  // exactly the right unsigned value, so no overflow handling is needed.
  always_comb begin
    mag1 = src1;
    mag2 = src2;
    if (signed_op && src1[WIDTH-1]) mag1 = (~src1) + ONE_W;
    if (signed_op && src2[WIDTH-1]) mag2 = (~src2) + ONE_W;
  end

  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    result_lo_d = result_lo_q;
    result_hi_d = result_hi_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;

    unique case (state_q)
      IDLE: begin
        if (start && !cancel) begin
          mcand_d  = {{WIDTH{1'b0}}, mag1};
          mplier_d = mag2;
          neg_d    = signed_op & (src1[WIDTH-1] ^ src2[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + ONE_C;
          if (cnt_q == LAST_C) state_d = FIX;
        end
      end
      FIX: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          {result_hi_d, result_lo_d} = neg_q ? ((~acc_q) + ONE_2W) : acc_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_lo_q <= '0;
      result_hi_q <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_lo_q <= result_lo_d;
      result_hi_q <= result_hi_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result_lo = result_lo_q;
  assign result_hi = result_hi_q;
  assign stall     = busy_q | (start & (state_q == IDLE) & ~cancel);

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl (WIDTH=32): directed table, multi-cycle
// corner sequences, then randomized operations against an arithmetic reference.
module tb_mul_seq_ctrl;
  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           reset, start, signed_op, cancel;
  logic [W-1:0]   src1, src2;
  logic           busy, stall, done;
  logic [W-1:0]   result_lo, result_hi;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mul_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_op(signed_op), .cancel(cancel),
    .src1(src1), .src2(src2), .busy(busy), .stall(stall), .done(done),
    .result_lo(result_lo), .result_hi(result_hi)
  );

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           s;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t tbl[8];
  logic [W-1:0] corners[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference product from plain arithmetic on the full-width values.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
    logic signed [2*W-1:0] sa, sb;
    logic [2*W-1:0] p;
    if (s) begin
      sa = {{W{a[W-1]}}, a};
      sb = {{W{b[W-1]}}, b};
      p  = sa * sb;
    end else begin
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    end
    return p;
  endfunction

  // One full operation: checks stall at start, done latency, done width,
  // busy length, stall in the done cycle and the product.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [2*W-1:0] exp, input string name);
    int busy_n, done_n, done_k;
    logic stall_at_done;
    src1 = a; src2 = b; signed_op = s; start = 1'b1;
    #1 chk({name, "_stall_start"}, 64'(stall), 64'(1));
    tick();
    start = 1'b0;
    busy_n = busy ? 1 : 0;
    done_n = 0; done_k = 0; stall_at_done = 1'b1;
    for (int k = 1; k <= int'(W) + 3; k++) begin
      tick();
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_k == 0) begin
          done_k = k;
          stall_at_done = stall;
        end
      end
    end
    chk({name, "_done_lat"}, 64'(done_k), 64'(W + 1));
    chk({name, "_done_cnt"}, 64'(done_n), 64'(1));
    chk({name, "_busy_len"}, 64'(busy_n), 64'(W + 1));
    chk({name, "_stall_done"}, 64'(stall_at_done), 64'(0));
    chk({name, "_result"}, {result_hi, result_lo}, exp);
  endtask

  initial begin
    logic [2*W-1:0] prev, exp;
    logic [W-1:0]   a, b;
    logic           s, flag;
    int             cancel_at, done_n, done_k, gap;

    // ---- reset state ----
    reset = 1'b1; start = 1'b1; cancel = 1'b0; signed_op = 1'b0; src1 = 3; src2 = 5;
    tick(); tick();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_result", {result_hi, result_lo}, 64'(0));
    chk("rst_stall_start", 64'(stall), 64'(1));
    cancel = 1'b1;
    #1 chk("rst_stall_cancel", 64'(stall), 64'(0));
    start = 1'b0; cancel = 1'b0; reset = 1'b0;
    tick();

    // ---- directed table ----
    tbl[0] = '{32'd3,        32'd5,        1'b0, 64'h0000_0000_0000_000F};
    tbl[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
    tbl[2] = '{32'hFFFFFFF9, 32'h00000006, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6};
    tbl[3] = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000_0000_0000_0000};
    tbl[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000_0000_0000_0001};
    tbl[5] = '{32'h80000000, 32'h00000001, 1'b1, 64'hFFFF_FFFF_8000_0000};
    tbl[6] = '{32'h80000000, 32'h00000002, 1'b0, 64'h0000_0001_0000_0000};
    tbl[7] = '{32'd7,        32'd0,        1'b0, 64'h0000_0000_0000_0000};
    for (int i = 0; i < 8; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].exp, $sformatf("tbl%0d", i));

    // ---- start held during RUN is ignored; cancel in RUN ----
    run_op(32'd3, 32'd5, 1'b0, 64'd15, "pre_cancel");
    src1 = 7; src2 = 7; signed_op = 1'b0; start = 1'b1;
    tick();
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("run_busy_e%0d", k), {63'd0, busy}, 64'(1));
    end
    cancel = 1'b1;
    tick();
    chk("cancel_busy", 64'(busy), 64'(0));
    chk("cancel_done", 64'(done), 64'(0));
    chk("cancel_stall_idle", 64'(stall), 64'(0));
    start = 1'b0; cancel = 1'b0;
    flag = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (busy || done) flag = 1'b1;
    end
    chk("cancel_no_restart", 64'(flag), 64'(0));
    chk("cancel_result_kept", {result_hi, result_lo}, 64'd15);

    // ---- reset mid-run ----
    src1 = 9; src2 = 9; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    reset = 1'b1;
    tick();
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_result", {result_hi, result_lo}, 64'(0));
    reset = 1'b0;
    run_op(32'd2, 32'd2, 1'b0, 64'd4, "post_rst");

    // ---- back-to-back ----
    src1 = 2; src2 = 3; signed_op = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < int'(W) + 5 && !done; k++) tick();
    chk("b2b_first_done", 64'(done), 64'(1));
    chk("b2b_first_result", {result_hi, result_lo}, 64'd6);
    src1 = 4; src2 = 4; start = 1'b1;
    tick();
    start = 1'b0;
    gap = 1;
    for (int k = 0; k < int'(W) + 5 && !done; k++) begin
      tick();
      gap++;
    end
    chk("b2b_gap", 64'(gap), 64'(W + 2));
    chk("b2b_second_result", {result_hi, result_lo}, 64'd16);
    repeat (2) tick();

    // ---- randomized operations with occasional cancel ----
    corners[0] = '0; corners[1] = 32'd1; corners[2] = '1;
    corners[3] = 32'h80000000; corners[4] = 32'h7FFFFFFF;
    prev = 64'd16;
    for (int i = 0; i < 60; i++) begin
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) a = corners[$urandom_range(0, 4)];
      if ($urandom_range(0, 3) == 0) b = corners[$urandom_range(0, 4)];
      s = 1'($urandom_range(0, 1));
      cancel_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W + 1)) : 0;
      exp = (cancel_at != 0) ? prev : ref_mul(a, b, s);
      src1 = a; src2 = b; signed_op = s; start = 1'b1;
      tick();
      start = 1'b0;
      done_n = 0; done_k = 0;
      for (int k = 1; k <= int'(W) + 3; k++) begin
        if (k == cancel_at) cancel = 1'b1;
        tick();
        cancel = 1'b0;
        if (done) begin
          done_n++;
          if (done_k == 0) done_k = k;
        end
      end
      chk($sformatf("rnd%0d_done_cnt", i), 64'(done_n), (cancel_at != 0) ? 64'(0) : 64'(1));
      chk($sformatf("rnd%0d_done_lat", i), 64'(done_k), (cancel_at != 0) ? 64'(0) : 64'(W + 1));
      chk($sformatf("rnd%0d_result", i), {result_hi, result_lo}, exp);
      prev = exp;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
